// File: rtl/prm_oblgc_feeder.sv
// rtl/prm_oblgc_feeder.sv - feeds obstacle vectors to the checker bank and ORs edge masks per frame
module prm_oblgc_feeder #(
   parameter int NUM_EDGES = 1024,
   parameter int SETTLE    = 1,
   parameter int CNT_W     = 16
) (
   input  logic                 CLK,
   input  logic                 RST_n,
   input  logic                 flush,
   input  logic                 obs_valid,
   output logic                 obs_ready,
   input  logic [14:0]          obs_data,
   input  logic                 obs_last,
   output logic [14:0]          chk_vec,
   input  logic [NUM_EDGES-1:0] chk_mask,
   output logic                 res_valid,
   input  logic                 res_ready,
   output logic [NUM_EDGES-1:0] res_mask,
   output logic [CNT_W-1:0]     res_count,
   output logic                 busy
);

   typedef enum logic [1:0] {
      IDLE,
      WAIT,
      SAMPLE,
      DONE
   } state_t;

   localparam logic [3:0] SETTLE_L = SETTLE[3:0];

   state_t               state;
   state_t               state_nxt;
   logic [3:0]           settle_cnt;
   logic                 last_flag;
   logic [NUM_EDGES-1:0] acc;
   logic                 accept;
   logic                 res_take;

   // obs_ready is only ever high in IDLE, so the state term is a belt-and-braces guard
   assign accept   = (state == IDLE) & obs_valid & obs_ready & ~flush;
   assign res_take = (state == DONE) & res_valid & res_ready;
   assign busy     = (state != IDLE) | (|acc);

   // next-state selection; flush overrides every state
   always_comb begin
      state_nxt = state;
      if (flush) begin
         state_nxt = IDLE;
      end else begin
         case (state)
            IDLE:    if (accept) state_nxt = WAIT;
            WAIT:    if (settle_cnt == 4'd0) state_nxt = SAMPLE;
            SAMPLE:  state_nxt = last_flag ? DONE : IDLE;
            DONE:    if (res_take) state_nxt = IDLE;
            default: state_nxt = IDLE;
         endcase
      end
   end

   // state register and registered ready, which looks ahead to the next state
   always_ff @(posedge CLK or negedge RST_n) begin
      if (!RST_n) begin
         state     <= IDLE;
         obs_ready <= 1'b0;
      end else begin
         state     <= state_nxt;
         obs_ready <= (state_nxt == IDLE) & ~flush;
      end
   end

   // checker drive, settle timing, mask accumulation and result hand-off
   always_ff @(posedge CLK or negedge RST_n) begin
      if (!RST_n) begin
         chk_vec    <= 15'd0;
         last_flag  <= 1'b0;
         settle_cnt <= 4'd0;
         acc        <= '0;
         res_valid  <= 1'b0;
         res_mask   <= '0;
         res_count  <= '0;
      end else begin
         if (accept) begin
            chk_vec    <= obs_data;
            last_flag  <= obs_last;
            settle_cnt <= SETTLE_L;
         end else if (state == WAIT && settle_cnt != 4'd0) begin
            settle_cnt <= settle_cnt - 4'd1;
         end

         if (flush) begin
            acc       <= '0;
            res_count <= '0;
            res_valid <= 1'b0;
         end else if (state == SAMPLE) begin
            acc <= acc | chk_mask;
            if (res_count != {CNT_W{1'b1}}) res_count <= res_count + CNT_W'(1);
            if (last_flag) begin
               res_valid <= 1'b1;
               res_mask  <= acc | chk_mask;
            end
         end else if (res_take) begin
            res_valid <= 1'b0;
            acc       <= '0;
            res_count <= '0;
         end
      end
   end

endmodule
